// File: rtl/pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : pc_fetch_ctrl
//  Purpose  : Program counter and instruction-fetch controller. It issues
//             instruction-memory requests and presents fetched words to
//             decode. A taken branch redirects the PC and flushes decode.
//  Revision : 1.0  initial release
// ============================================================================
module pc_fetch_ctrl #(
   parameter int unsigned       ADDR_W    = 16,
   parameter int unsigned       DATA_W    = 16,
   parameter logic [ADDR_W-1:0] RESET_PC  = '0,
   parameter logic [DATA_W-1:0] NOP_INSTR = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              branch_valid_i,
   input  logic              pcsrc_i,
   input  logic [ADDR_W-1:0] br_target_i,
   input  logic              stall_i,
   output logic              imem_req_o,
   output logic [ADDR_W-1:0] imem_addr_o,
   input  logic              imem_ack_i,
   input  logic [DATA_W-1:0] imem_rdata_i,
   output logic              if_valid_o,
   output logic [DATA_W-1:0] if_instr_o,
   output logic [ADDR_W-1:0] if_pc_o,
   output logic              flush_o
);

   typedef enum logic [1:0] {
      S_FETCH   = 2'd0,
      S_VALID   = 2'd1,
      S_DISCARD = 2'd2
   } state_t;

   state_t            state_q,     state_d;
   logic [ADDR_W-1:0] pc_q,        pc_d;
   logic              imem_req_q,  imem_req_d;
   logic [ADDR_W-1:0] imem_addr_q, imem_addr_d;
   logic              if_valid_q,  if_valid_d;
   logic [DATA_W-1:0] if_instr_q,  if_instr_d;
   logic [ADDR_W-1:0] if_pc_q,     if_pc_d;
   logic              flush_q,     flush_d;

   logic              redirect_w;
   logic              ack_seen_w;
   logic [ADDR_W-1:0] pc_inc_w;

   // A taken branch; an ack only counts while a request is actually open.
   assign redirect_w = branch_valid_i & ~pcsrc_i;
   assign ack_seen_w = imem_req_q & imem_ack_i;
   assign pc_inc_w   = pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

   // Next-state and next-output decode for the fetch FSM.
   always_comb begin
      state_d     = state_q;
      pc_d        = pc_q;
      imem_req_d  = imem_req_q;
      imem_addr_d = imem_addr_q;
      if_valid_d  = if_valid_q;
      if_instr_d  = if_instr_q;
      if_pc_d     = if_pc_q;
      flush_d     = 1'b0;

      // Redirect overrides stall and any same-cycle response: decode is
      // emptied and the PC moves to the branch target.
      if (redirect_w) begin
         pc_d       = br_target_i;
         flush_d    = 1'b1;
         if_valid_d = 1'b0;
         if_instr_d = NOP_INSTR;
      end

      case (state_q)
         S_FETCH: begin
            if (redirect_w) begin
               if (imem_req_q && !imem_ack_i) begin
                  // Request still open: keep the old address until the
                  // memory answers, then throw that answer away.
                  state_d = S_DISCARD;
               end else begin
                  // Either nothing outstanding or it completed this cycle;
                  // the word is dropped and the target is requested at once.
                  state_d     = S_FETCH;
                  imem_req_d  = 1'b1;
                  imem_addr_d = br_target_i;
               end
            end else if (ack_seen_w) begin
               state_d    = S_VALID;
               if_instr_d = imem_rdata_i;
               if_pc_d    = pc_q;
               if_valid_d = 1'b1;
               pc_d       = pc_inc_w;
               imem_req_d = 1'b0;
            end else begin
               // First cycle after reset raises the request; afterwards this
               // simply holds request and address until the ack.
               imem_req_d  = 1'b1;
               imem_addr_d = pc_q;
            end
         end

         S_VALID: begin
            if (redirect_w) begin
               state_d     = S_FETCH;
               imem_req_d  = 1'b1;
               imem_addr_d = br_target_i;
            end else if (!stall_i) begin
               // Decode takes the word; the next request goes out immediately
               // so a fetch completes every second cycle at best.
               state_d     = S_FETCH;
               if_valid_d  = 1'b0;
               if_instr_d  = NOP_INSTR;
               imem_req_d  = 1'b1;
               imem_addr_d = pc_q;
            end
         end

         S_DISCARD: begin
            // The stale response closes the abandoned request. A redirect in
            // the same cycle has already re-targeted pc_d, so fetch from it.
            if (ack_seen_w) begin
               state_d     = S_FETCH;
               imem_req_d  = 1'b1;
               imem_addr_d = redirect_w ? br_target_i : pc_q;
            end
         end

         default: begin
            state_d    = S_FETCH;
            imem_req_d = 1'b0;
         end
      endcase
   end

   // State and registered outputs; reset abandons any open request at once.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_FETCH;
         pc_q        <= RESET_PC;
         imem_req_q  <= 1'b0;
         imem_addr_q <= RESET_PC;
         if_valid_q  <= 1'b0;
         if_instr_q  <= NOP_INSTR;
         if_pc_q     <= RESET_PC;
         flush_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         pc_q        <= pc_d;
         imem_req_q  <= imem_req_d;
         imem_addr_q <= imem_addr_d;
         if_valid_q  <= if_valid_d;
         if_instr_q  <= if_instr_d;
         if_pc_q     <= if_pc_d;
         flush_q     <= flush_d;
      end
   end

   assign imem_req_o  = imem_req_q;
   assign imem_addr_o = imem_addr_q;
   assign if_valid_o  = if_valid_q;
   assign if_instr_o  = if_instr_q;
   assign if_pc_o     = if_pc_q;
   assign flush_o     = flush_q;

endmodule
`default_nettype wire

// File: tb/tb_pc_fetch_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : tb_pc_fetch_ctrl
//  Purpose  : Directed self-checking bench for pc_fetch_ctrl (default reset
//             PC instance plus a RESET_PC=FFFF instance for wrap checks).
//  Revision : 1.0  initial release
// ============================================================================
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Instance 0: default parameters
   logic        rst0 = 1'b1;
   logic        bv0 = 1'b0, pcsrc0 = 1'b0, stall0 = 1'b0, ack0 = 1'b0;
   logic [15:0] tgt0 = 16'h0000, rdata0 = 16'h0000;
   logic        req0, valid0, flush0;
   logic [15:0] addr0, instr0, ifpc0;

   // Instance 1: reset PC at the top of the address space
   logic        rst1 = 1'b1;
   logic        bv1 = 1'b0, pcsrc1 = 1'b0, stall1 = 1'b0, ack1 = 1'b0;
   logic [15:0] tgt1 = 16'h0000, rdata1 = 16'h0000;
   logic        req1, valid1, flush1;
   logic [15:0] addr1, instr1, ifpc1;

   pc_fetch_ctrl u_dut0 (
      .clk            (clk),
      .rst            (rst0),
      .branch_valid_i (bv0),
      .pcsrc_i        (pcsrc0),
      .br_target_i    (tgt0),
      .stall_i        (stall0),
      .imem_req_o     (req0),
      .imem_addr_o    (addr0),
      .imem_ack_i     (ack0),
      .imem_rdata_i   (rdata0),
      .if_valid_o     (valid0),
      .if_instr_o     (instr0),
      .if_pc_o        (ifpc0),
      .flush_o        (flush0)
   );

   pc_fetch_ctrl #(.RESET_PC(16'hFFFF)) u_dut1 (
      .clk            (clk),
      .rst            (rst1),
      .branch_valid_i (bv1),
      .pcsrc_i        (pcsrc1),
      .br_target_i    (tgt1),
      .stall_i        (stall1),
      .imem_req_o     (req1),
      .imem_addr_o    (addr1),
      .imem_ack_i     (ack1),
      .imem_rdata_i   (rdata1),
      .if_valid_o     (valid1),
      .if_instr_o     (instr1),
      .if_pc_o        (ifpc1),
      .flush_o        (flush1)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Advance one clock; outputs are sampled and inputs driven 1 time unit later.
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      // ---- 1: reset held for 3 cycles, then released
      step(); step(); step();
      chk("rst_req",   req0,   0);
      chk("rst_valid", valid0, 0);
      chk("rst_flush", flush0, 0);
      chk("rst_instr", instr0, 16'h0000);
      rst0 = 1'b0;
      step();
      chk("post_rst_req",  req0,  1);
      chk("post_rst_addr", addr0, 16'h0000);

      // ---- 2: ack latency 1, A000 then A001
      ack0 = 1'b1; rdata0 = 16'hA000;
      step();
      chk("f0_valid", valid0, 1);
      chk("f0_pc",    ifpc0,  16'h0000);
      chk("f0_instr", instr0, 16'hA000);
      chk("f0_req",   req0,   0);
      ack0 = 1'b0;
      step();
      chk("gap_valid", valid0, 0);
      chk("gap_instr", instr0, 16'h0000);
      chk("gap_req",   req0,   1);
      chk("gap_addr",  addr0,  16'h0001);
      ack0 = 1'b1; rdata0 = 16'hA001;
      step();
      chk("f1_valid", valid0, 1);
      chk("f1_pc",    ifpc0,  16'h0001);
      chk("f1_instr", instr0, 16'hA001);
      ack0 = 1'b0;

      // ---- 3: stall holds the instruction for 3 cycles
      stall0 = 1'b1;
      for (int i = 0; i < 3; i++) begin
         step();
         chk("stall_valid", valid0, 1);
         chk("stall_pc",    ifpc0,  16'h0001);
         chk("stall_instr", instr0, 16'hA001);
         chk("stall_req",   req0,   0);
      end
      stall0 = 1'b0;
      step();
      chk("unstall_req",   req0,   1);
      chk("unstall_addr",  addr0,  16'h0002);
      chk("unstall_valid", valid0, 0);

      // ---- 4: redirect while request to 0002 is outstanding
      bv0 = 1'b1; pcsrc0 = 1'b0; tgt0 = 16'h0040;
      step();
      chk("rd_flush", flush0, 1);
      chk("rd_req",   req0,   1);
      chk("rd_addr",  addr0,  16'h0002);
      chk("rd_valid", valid0, 0);
      bv0 = 1'b0;
      step();
      chk("disc_flush", flush0, 0);
      chk("disc_addr",  addr0,  16'h0002);
      ack0 = 1'b1; rdata0 = 16'hBEEF;
      step();
      chk("disc_valid", valid0, 0);
      chk("disc_instr", instr0, 16'h0000);
      chk("disc_req",   req0,   1);
      chk("disc_next",  addr0,  16'h0040);
      rdata0 = 16'hC040;
      step();
      chk("t40_valid", valid0, 1);
      chk("t40_pc",    ifpc0,  16'h0040);
      chk("t40_instr", instr0, 16'hC040);
      ack0 = 1'b0;

      // ---- 5: branch_valid with pcsrc=1 is not a redirect
      bv0 = 1'b1; pcsrc0 = 1'b1; tgt0 = 16'h0040;
      step();
      chk("seq_flush", flush0, 0);
      chk("seq_addr",  addr0,  16'h0041);
      bv0 = 1'b0;
      ack0 = 1'b1; rdata0 = 16'hC041;
      step();
      chk("t41_pc", ifpc0, 16'h0041);
      ack0 = 1'b0;
      // redirect beats stall
      stall0 = 1'b1; bv0 = 1'b1; pcsrc0 = 1'b0; tgt0 = 16'h0100;
      step();
      chk("rs_flush", flush0, 1);
      chk("rs_valid", valid0, 0);
      chk("rs_instr", instr0, 16'h0000);
      chk("rs_addr",  addr0,  16'h0100);
      bv0 = 1'b0; stall0 = 1'b0;
      step();
      chk("rs_flush_end", flush0, 0);
      chk("rs_req",       req0,   1);
      // redirect beats a same-cycle ack
      ack0 = 1'b1; rdata0 = 16'hDEAD; bv0 = 1'b1; tgt0 = 16'h0200;
      step();
      chk("ra_flush", flush0, 1);
      chk("ra_valid", valid0, 0);
      chk("ra_addr",  addr0,  16'h0200);
      chk("ra_req",   req0,   1);
      ack0 = 1'b0; bv0 = 1'b0;
      step();
      chk("ra_flush_end", flush0, 0);
      // async reset mid-fetch drops the request immediately
      rst0 = 1'b1;
      #1;
      chk("arst_req",  req0,  0);
      chk("arst_addr", addr0, 16'h0000);
      step();
      rst0 = 1'b0;
      step();
      chk("arst_restart", addr0, 16'h0000);
      chk("arst_req2",    req0,  1);

      // ---- 6: RESET_PC=FFFF, wrap to 0000
      rst1 = 1'b0;
      step();
      chk("w_req",  req1,  1);
      chk("w_addr", addr1, 16'hFFFF);
      ack1 = 1'b1; rdata1 = 16'hF0FF;
      step();
      chk("w_pc",    ifpc1,  16'hFFFF);
      chk("w_instr", instr1, 16'hF0FF);
      ack1 = 1'b0;
      step();
      chk("w_wrap", addr1, 16'h0000);
      chk("w_req2", req1,  1);
      rst1 = 1'b1;
      #1;
      chk("w_arst_req",  req1,  0);
      chk("w_arst_addr", addr1, 16'hFFFF);
      step();
      rst1 = 1'b0;
      step();
      chk("w_restart", addr1, 16'hFFFF);
      chk("w_req3",    req1,  1);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
